// File: rtl/m_enc_pkg.sv
// Shared definitions for the Manchester link: FSM state codes, line idle level,
// and frame-length helper (also consumed by the m_dec receive side).
package m_enc_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_H1   = 2'd1;
  localparam logic [1:0] S_H2   = 2'd2;

  localparam logic LINE_IDLE = 1'b0;

  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned parity_en);
    return data_w + ((parity_en != 0) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/m_enc_shift.sv
// Load/shift register for the Manchester encoder: MSB-first data out plus a
// running XOR of the data bits that have already been sent (even parity).
module m_enc_shift #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              msb_nxt_o,
  output logic              par_nxt_o
);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic              par_q, par_d;

  always_comb begin
    sr_d  = sr_q;
    par_d = par_q;
    if (load_i) begin
      sr_d  = din_i;
      par_d = 1'b0;
    end else begin
      if (acc_i) begin
        par_d = par_q ^ sr_q[DATA_W-1];
      end
      if (shift_i) begin
        sr_d = {sr_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      par_q <= par_d;
    end
  end

  // Next-state views let the owner register line outputs on the edge that enters a state.
  assign msb_nxt_o = sr_d[DATA_W-1];
  assign par_nxt_o = par_d;

endmodule

// File: rtl/m_enc.sv
// Manchester encoder (transmit end of the m_dec link): valid/ready word intake,
// MSB-first serialisation at two half-bits per bit, optional even-parity bit.
module m_enc
  import m_enc_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic              clk_enc,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              data_m,
  output logic              tx_active,
  output logic              bit_strobe,
  output logic              done
);

  localparam int unsigned FRAME_BITS = frame_bits(DATA_W, PARITY_EN);
  localparam int unsigned CNT_W      = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_BITS - 1);
  localparam bit HAS_PAR = (PARITY_EN != 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_m_q, data_m_d;
  logic             tx_active_q, tx_active_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             done_q, done_d;

  logic load, shift, acc;
  logic last, xfer, par_bit_now;
  logic msb_nxt, par_nxt, cur_bit_nxt;

  m_enc_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk_i     (clk_enc),
    .rst_i     (rst),
    .load_i    (load),
    .shift_i   (shift),
    .acc_i     (acc),
    .din_i     (din),
    .msb_nxt_o (msb_nxt),
    .par_nxt_o (par_nxt)
  );

  assign last        = (cnt_q == '0);
  assign par_bit_now = HAS_PAR && last;
  assign din_ready   = (state_q == S_IDLE) || ((state_q == S_H2) && last);
  assign xfer        = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    acc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          load    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_H1;
        end
      end
      S_H1: begin
        state_d = S_H2;
      end
      S_H2: begin
        acc = !par_bit_now;
        if (!last) begin
          shift   = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = S_H1;
        end else if (xfer) begin
          load    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_H1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs describe the state being entered, so they are derived from next-state values.
  always_comb begin
    cur_bit_nxt  = (HAS_PAR && (cnt_d == '0)) ? par_nxt : msb_nxt;
    data_m_d     = LINE_IDLE;
    tx_active_d  = (state_d != S_IDLE);
    bit_strobe_d = (state_d == S_H2);
    done_d       = (state_d == S_H2) && (cnt_d == '0);
    case (state_d)
      S_H1:    data_m_d = ~cur_bit_nxt;
      S_H2:    data_m_d = cur_bit_nxt;
      default: data_m_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk_enc) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      data_m_q     <= LINE_IDLE;
      tx_active_q  <= 1'b0;
      bit_strobe_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_m_q     <= data_m_d;
      tx_active_q  <= tx_active_d;
      bit_strobe_q <= bit_strobe_d;
      done_q       <= done_d;
    end
  end

  assign data_m     = data_m_q;
  assign tx_active  = tx_active_q;
  assign bit_strobe = bit_strobe_q;
  assign done       = done_q;

endmodule

// File: tb/tb_m_enc.sv
// Bench for m_enc: a plain-data instance and a parity instance driven side by side,
// each compared every cycle against a queue-of-half-bits reference model.
module tb_m_enc;

  logic       clk_enc = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid0, din_valid1;
  logic       din_ready0, din_ready1;
  logic       data_m0, data_m1;
  logic       tx_active0, tx_active1;
  logic       bit_strobe0, bit_strobe1;
  logic       done0, done1;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk_enc = ~clk_enc;

  m_enc #(.DATA_W(8), .PARITY_EN(0)) u_dut (
    .clk_enc(clk_enc), .rst(rst), .din(din), .din_valid(din_valid0),
    .din_ready(din_ready0), .data_m(data_m0), .tx_active(tx_active0),
    .bit_strobe(bit_strobe0), .done(done0)
  );

  m_enc #(.DATA_W(8), .PARITY_EN(1)) u_dut_p (
    .clk_enc(clk_enc), .rst(rst), .din(din), .din_valid(din_valid1),
    .din_ready(din_ready1), .data_m(data_m1), .tx_active(tx_active1),
    .bit_strobe(bit_strobe1), .done(done1)
  );

  // Reference model: per instance, the half-bit currently on the line plus queued halves.
  // Each entry is {line level, strobe, done}.
  logic       cur_act[2];
  logic [2:0] cur[2];
  logic [2:0] pend0[$];
  logic [2:0] pend1[$];
  bit         known = 1'b0;

  logic [31:0] hist0 = '0;
  logic [31:0] hist1 = '0;
  int unsigned rdy_cnt0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready(input int k);
    return !cur_act[k] || cur[k][0];
  endfunction

  task automatic push_half(input int k, input logic [2:0] h);
    if (k == 0) pend0.push_back(h);
    else        pend1.push_back(h);
  endtask

  task automatic model_edge(input int k, input bit r, input bit v, input logic [7:0] w);
    logic [8:0] bits;
    int         nb;
    logic [2:0] h;
    bit         have;
    if (r) begin
      cur_act[k] = 1'b0;
      cur[k]     = 3'b000;
      if (k == 0) pend0.delete();
      else        pend1.delete();
      return;
    end
    if (v && model_ready(k)) begin
      nb = (k == 0) ? 8 : 9;
      bits = {w, ^w};
      for (int j = 0; j < nb; j++) begin
        push_half(k, {~bits[8-j], 1'b0, 1'b0});
        push_half(k, {bits[8-j], 1'b1, (j == nb - 1)});
      end
    end
    have = 1'b0;
    h    = 3'b000;
    if (k == 0 && pend0.size() > 0) begin h = pend0.pop_front(); have = 1'b1; end
    if (k == 1 && pend1.size() > 0) begin h = pend1.pop_front(); have = 1'b1; end
    cur_act[k] = have;
    cur[k]     = h;
  endtask

  task automatic tick(input bit r, input bit v0, input bit v1, input logic [7:0] w);
    rst        = r;
    din_valid0 = v0;
    din_valid1 = v1;
    din        = w;
    #1;
    if (known) begin
      chk("din_ready0", din_ready0, model_ready(0));
      chk("din_ready1", din_ready1, model_ready(1));
    end
    if (din_ready0 === 1'b1) rdy_cnt0++;
    @(posedge clk_enc);
    model_edge(0, r, v0, w);
    model_edge(1, r, v1, w);
    if (r) known = 1'b1;
    @(negedge clk_enc);
    #1;
    hist0 = {hist0[30:0], data_m0};
    hist1 = {hist1[30:0], data_m1};
    if (known) begin
      chk("data_m0",     data_m0,     cur[0][2]);
      chk("tx_active0",  tx_active0,  cur_act[0]);
      chk("bit_strobe0", bit_strobe0, cur[0][1]);
      chk("done0",       done0,       cur[0][0]);
      chk("data_m1",     data_m1,     cur[1][2]);
      chk("tx_active1",  tx_active1,  cur_act[1]);
      chk("bit_strobe1", bit_strobe1, cur[1][1]);
      chk("done1",       done1,       cur[1][0]);
    end
  endtask

  initial begin
    cur_act[0] = 1'b0; cur_act[1] = 1'b0;
    cur[0] = 3'b000;   cur[1] = 3'b000;
    rst = 1'b1; din = '0; din_valid0 = 1'b0; din_valid1 = 1'b0;
    @(negedge clk_enc);

    // Reset idle, including rst together with din_valid.
    tick(1, 0, 0, 8'h00);
    tick(1, 1, 1, 8'hA5);
    tick(1, 0, 0, 8'h00);
    chk("reset_data_m", data_m0, 1'b0);
    chk("reset_ready",  din_ready0, 1'b1);
    chk("reset_active", tx_active0, 1'b0);
    chk("reset_done",   done0, 1'b0);

    // Single word 8'hA5.
    tick(0, 1, 0, 8'hA5);
    for (int i = 0; i < 15; i++) tick(0, 0, 0, 8'h00);
    chk("a5_halves", hist0[15:0], 16'h6699);
    chk("a5_done",   done0, 1'b1);
    tick(0, 0, 0, 8'h00);
    chk("a5_idle", tx_active0, 1'b0);

    // Back-to-back 8'hFF then 8'h00 with din_valid held high.
    rdy_cnt0 = 0;
    tick(0, 1, 0, 8'hFF);
    for (int i = 0; i < 16; i++) tick(0, 1, 0, 8'h00);
    for (int i = 0; i < 15; i++) tick(0, 0, 0, 8'h00);
    chk("b2b_halves", hist0, 32'h5555AAAA);
    tick(0, 0, 0, 8'h00);
    chk("b2b_ready_count", rdy_cnt0, 3);
    chk("b2b_idle", tx_active0, 1'b0);

    // Parity instance: 8'h07 -> parity 1, 8'h03 -> parity 0.
    tick(0, 0, 1, 8'h07);
    for (int i = 0; i < 17; i++) tick(0, 0, 0, 8'h00);
    chk("par07_halves", hist1[17:0], 18'b10_10_10_10_10_01_01_01_01);
    tick(0, 0, 0, 8'h00);
    tick(0, 0, 1, 8'h03);
    for (int i = 0; i < 17; i++) tick(0, 0, 0, 8'h00);
    chk("par03_halves", hist1[17:0], 18'b10_10_10_10_10_10_01_01_10);
    tick(0, 0, 0, 8'h00);

    // Reset mid-frame, then a clean 8'h3C.
    tick(0, 1, 0, 8'hA5);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 8'h00);
    tick(1, 0, 0, 8'h00);
    chk("midrst_data_m", data_m0, 1'b0);
    chk("midrst_active", tx_active0, 1'b0);
    tick(0, 1, 0, 8'h3C);
    for (int i = 0; i < 15; i++) tick(0, 0, 0, 8'h00);
    chk("3c_halves", hist0[15:0], 16'hA55A);
    tick(0, 0, 0, 8'h00);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0),
           8'($urandom));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
